// File: rtl/stream_demux_w_qos.sv
// Packet-level 1-to-N stream router with a one-entry register slice per output.
// Define DEMUX_DROP_CNT_EN to add the saturating dropped-packet counter port.
module stream_demux_w_qos #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [T_DATA_WIDTH-1:0]              s_data_in,
    input  logic [T_QOS__WIDTH-1:0]              s_qos_in,
    input  logic [T_ID___WIDTH-1:0]              s_id_in,
    input  logic                                 s_last_in,
    input  logic                                 s_valid_in,
    output logic                                 s_ready_out,
    output logic [STREAM_COUNT*T_DATA_WIDTH-1:0] m_data_out,
    output logic [STREAM_COUNT*T_QOS__WIDTH-1:0] m_qos_out,
    output logic [STREAM_COUNT-1:0]              m_last_out,
    output logic [STREAM_COUNT-1:0]              m_valid_out,
`ifdef DEMUX_DROP_CNT_EN
    output logic [15:0]                          drop_cnt_out,
`endif
    input  logic [STREAM_COUNT-1:0]              m_ready_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } state_t;

    localparam logic [T_ID___WIDTH:0] LP_COUNT = (T_ID___WIDTH+1)'(STREAM_COUNT);

    state_t                  r_state;
    logic [T_ID___WIDTH-1:0] r_dest;
    logic [STREAM_COUNT-1:0] r_valid;
    logic [T_DATA_WIDTH-1:0] r_data [STREAM_COUNT];
    logic [T_QOS__WIDTH-1:0] r_qos  [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] r_last;

    logic                    w_idle;
    logic [T_ID___WIDTH-1:0] w_dest;
    logic                    w_in_range;
    logic                    w_drop;
    logic                    w_slot_rdy;
    logic                    w_accept;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_dest     = w_idle ? s_id_in : r_dest;
    assign w_in_range = ({1'b0, s_id_in} < LP_COUNT);
    assign w_drop     = (r_state == ST_DROP) | (w_idle & !w_in_range);

    // Ready depends only on the slice of the current destination.
    always_comb begin
        w_slot_rdy = 1'b0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            if (w_dest == T_ID___WIDTH'(k)) begin
                w_slot_rdy = !r_valid[k] | m_ready_in[k];
            end
        end
    end

    assign s_ready_out = rst_n & (w_drop | w_slot_rdy);
    assign w_accept    = s_valid_in & s_ready_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
        end else if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!s_last_in) begin
                        r_state <= w_in_range ? ST_ACTIVE : ST_DROP;
                        if (w_in_range) r_dest <= s_id_in;
                    end
                end
                ST_ACTIVE: begin
                    if (s_last_in) r_state <= ST_IDLE;
                end
                ST_DROP: begin
                    if (s_last_in) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A load wins over a drain in the same cycle, so valid stays set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STREAM_COUNT; k++) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_qos[k]   <= '0;
                r_last[k]  <= 1'b0;
            end else if (w_accept && !w_drop && w_dest == T_ID___WIDTH'(k)) begin
                r_valid[k] <= 1'b1;
                r_data[k]  <= s_data_in;
                r_qos[k]   <= s_qos_in;
                r_last[k]  <= s_last_in;
            end else if (m_ready_in[k]) begin
                r_valid[k] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_out
        assign m_data_out[g*T_DATA_WIDTH +: T_DATA_WIDTH] = r_data[g];
        assign m_qos_out[g*T_QOS__WIDTH +: T_QOS__WIDTH]  = r_qos[g];
    end

    assign m_last_out  = r_last;
    assign m_valid_out = r_valid;

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_idle && !w_in_range && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_out = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux_w_qos.sv
// Randomized bench for stream_demux_w_qos against a packet-level queue model.
// Three outputs so that id 3 exercises the out-of-range drop path.
module tb_stream_demux_w_qos;

    localparam int DW = 8;
    localparam int QW = 2;
    localparam int SC = 3;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic          l;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    s_data_in;
    logic [QW-1:0]    s_qos_in;
    logic [IW-1:0]    s_id_in;
    logic             s_last_in;
    logic             s_valid_in;
    logic             s_ready_out;
    logic [SC*DW-1:0] m_data_out;
    logic [SC*QW-1:0] m_qos_out;
    logic [SC-1:0]    m_last_out;
    logic [SC-1:0]    m_valid_out;
    logic [SC-1:0]    m_ready_in;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0]      drop_cnt_out;
`endif

    always #5 clk = ~clk;

    stream_demux_w_qos #(
        .T_DATA_WIDTH(DW),
        .T_QOS__WIDTH(QW),
        .STREAM_COUNT(SC),
        .T_ID___WIDTH(IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data_in   (s_data_in),
        .s_qos_in    (s_qos_in),
        .s_id_in     (s_id_in),
        .s_last_in   (s_last_in),
        .s_valid_in  (s_valid_in),
        .s_ready_out (s_ready_out),
        .m_data_out  (m_data_out),
        .m_qos_out   (m_qos_out),
        .m_last_out  (m_last_out),
        .m_valid_out (m_valid_out),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt_out(drop_cnt_out),
`endif
        .m_ready_in  (m_ready_in)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    beat_t mq [SC][$];
    bit    in_pkt;
    bit    pkt_drop;
    int    pkt_dest;
    int    mcnt;

    int            g_rem;
    int            g_id;
    bit            g_first;
    logic [DW-1:0] g_data;
    logic [QW-1:0] g_qos;

    task automatic new_beat();
        g_data = DW'($urandom);
        g_qos  = QW'($urandom);
    endtask

    task automatic new_pkt();
        g_rem   = $urandom_range(1, 4);
        g_id    = $urandom_range(0, 3);
        g_first = 1'b1;
        new_beat();
    endtask

    initial begin
        bit    acc;
        bit    erdy;
        bit    edrop;
        int    ed;
        beat_t b;

        rst_n      = 1'b0;
        s_valid_in = 1'b0;
        s_data_in  = '0;
        s_qos_in   = '0;
        s_id_in    = '0;
        s_last_in  = 1'b0;
        m_ready_in = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(s_ready_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(m_valid_out), 32'd0);
        chk("rst_data", 32'(m_data_out), 32'd0);
        chk("rst_qos", 32'(m_qos_out), 32'd0);
        chk("rst_last", 32'(m_last_out), 32'd0);
`ifdef DEMUX_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt_out), 32'd0);
`endif
        in_pkt   = 1'b0;
        pkt_drop = 1'b0;
        pkt_dest = 0;
        mcnt     = 0;
        new_pkt();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n = !(cyc == 1500 || cyc == 1501 || cyc == 2700);
            if (cyc < 300) begin
                s_valid_in = 1'b1;
                m_ready_in = '1;
            end else begin
                s_valid_in = ($urandom_range(0, 3) != 0);
                m_ready_in = SC'($urandom);
            end
            s_id_in   = g_first ? IW'(g_id) : IW'($urandom_range(0, 3));
            s_last_in = (g_rem == 1);
            s_data_in = g_data;
            s_qos_in  = g_qos;
            #1;

            edrop = in_pkt ? pkt_drop : (s_id_in >= IW'(SC));
            ed    = in_pkt ? pkt_dest : int'(s_id_in);
            if (!rst_n)     erdy = 1'b0;
            else if (edrop) erdy = 1'b1;
            else            erdy = (mq[ed].size() == 0) || m_ready_in[ed];
            chk("ready", 32'(s_ready_out), 32'(erdy));

            for (int k = 0; k < SC; k++) begin
                chk($sformatf("valid%0d", k), 32'(m_valid_out[k]),
                    32'(mq[k].size() != 0));
                if (mq[k].size() != 0) begin
                    b = mq[k][0];
                    chk($sformatf("data%0d", k),
                        32'(m_data_out[k*DW +: DW]), 32'(b.d));
                    chk($sformatf("qos%0d", k),
                        32'(m_qos_out[k*QW +: QW]), 32'(b.q));
                    chk($sformatf("last%0d", k),
                        32'(m_last_out[k]), 32'(b.l));
                end
            end
`ifdef DEMUX_DROP_CNT_EN
            chk("drop_cnt", 32'(drop_cnt_out), 32'(mcnt));
`endif
            acc = s_valid_in && erdy;

            @(posedge clk);
            if (!rst_n) begin
                for (int k = 0; k < SC; k++) mq[k].delete();
                in_pkt = 1'b0;
                mcnt   = 0;
                new_pkt();
            end else begin
                for (int k = 0; k < SC; k++) begin
                    if (mq[k].size() != 0 && m_ready_in[k]) void'(mq[k].pop_front());
                end
                if (acc) begin
                    b.d = s_data_in;
                    b.q = s_qos_in;
                    b.l = s_last_in;
                    if (!in_pkt) begin
                        pkt_dest = int'(s_id_in);
                        pkt_drop = (s_id_in >= IW'(SC));
                        if (pkt_drop && mcnt < 16'hFFFF) mcnt++;
                        in_pkt = !s_last_in;
                    end else if (s_last_in) begin
                        in_pkt = 1'b0;
                    end
                    if (!pkt_drop) mq[pkt_dest].push_back(b);
                    g_rem--;
                    g_first = 1'b0;
                    if (g_rem == 0) new_pkt();
                    else new_beat();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
